// File: rtl/router_register_p.sv
// Packet register stage of the 1x3 router: captures the header, forwards words to the
// destination FIFO, buffers words during FIFO stalls, and checks packet parity and length.
module router_register_p #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_BITS   = 2,
  parameter int HOLD_DEPTH  = 2,
  parameter int PARITY_MODE = 0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  pkt_valid,
  input  logic [DATA_WIDTH-1:0]                 data_in,
  input  logic                                  fifo_full,
  input  logic                                  rst_int_reg,
  input  logic                                  detect_add,
  input  logic                                  lfd_state,
  input  logic                                  ld_state,
  input  logic                                  laf_state,
  input  logic                                  full_state,
  output logic [DATA_WIDTH-1:0]                 dout,
  output logic                                  dout_valid,
  output logic                                  parity_done,
  output logic                                  low_pkt_valid,
  output logic                                  error,
  output logic                                  len_error,
  output logic [$clog2(HOLD_DEPTH+1)-1:0]       hold_count,
  output logic                                  hold_ovf
);

  localparam int LEN_WIDTH = DATA_WIDTH - ADDR_BITS;
  localparam int CNT_WIDTH = $clog2(HOLD_DEPTH + 1);
  localparam int SLOTS     = 1 << CNT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(HOLD_DEPTH);

  logic [DATA_WIDTH-1:0] header_reg;
  logic [DATA_WIDTH-1:0] accumulator;
  logic [DATA_WIDTH-1:0] packet_parity;
  logic [LEN_WIDTH:0]    payload_count;
  logic                  check_pending;
  logic [DATA_WIDTH-1:0] hold_buf [SLOTS];

  logic sel_lfd, sel_laf, sel_ld;
  logic buf_empty, buf_full;
  logic do_forward, want_push, do_push, do_drop, do_pop;
  logic payload_word, parity_word;

  function automatic logic [DATA_WIDTH-1:0] fold(input logic [DATA_WIDTH-1:0] acc,
                                                 input logic [DATA_WIDTH-1:0] word);
    if (PARITY_MODE == 1) return acc + word;
    else                  return acc ^ word;
  endfunction

  // Strobe priority is detect_add > lfd_state > laf_state > ld_state, so push and pop
  // can never coincide and hold_count moves by at most one per cycle.
  always_comb begin
    sel_lfd      = !detect_add && lfd_state;
    sel_laf      = !detect_add && !lfd_state && laf_state;
    sel_ld       = !detect_add && !lfd_state && !laf_state && ld_state;
    buf_empty    = (hold_count == '0);
    buf_full     = (hold_count == DEPTH_C);
    do_forward   = sel_ld && !fifo_full && buf_empty;
    want_push    = sel_ld && (fifo_full || !buf_empty) && !full_state;
    do_push      = want_push && !buf_full;
    do_drop      = want_push && buf_full;
    do_pop       = sel_laf && !fifo_full && !buf_empty && !full_state;
    payload_word = (do_forward || do_push) && pkt_valid;
    parity_word  = (do_forward || do_push) && !pkt_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      header_reg    <= '0;
      accumulator   <= '0;
      packet_parity <= '0;
      payload_count <= '0;
      check_pending <= 1'b0;
      dout          <= '0;
      dout_valid    <= 1'b0;
      parity_done   <= 1'b0;
      low_pkt_valid <= 1'b0;
      error         <= 1'b0;
      len_error     <= 1'b0;
      hold_count    <= '0;
      hold_ovf      <= 1'b0;
      for (int i = 0; i < SLOTS; i++) hold_buf[i] <= '0;
    end else begin
      dout_valid    <= 1'b0;
      check_pending <= 1'b0;

      if (detect_add && pkt_valid) begin
        header_reg    <= data_in;
        accumulator   <= '0;
        payload_count <= '0;
        hold_count    <= '0;
        hold_ovf      <= 1'b0;
      end

      if (sel_lfd) begin
        dout        <= header_reg;
        dout_valid  <= 1'b1;
        accumulator <= fold(accumulator, header_reg);
      end

      if (do_forward) begin
        dout       <= data_in;
        dout_valid <= 1'b1;
      end

      if (do_push) begin
        hold_buf[hold_count] <= data_in;
        hold_count           <= hold_count + CNT_WIDTH'(1);
      end

      if (do_drop) hold_ovf <= 1'b1;

      if (do_pop) begin
        dout       <= hold_buf[0];
        dout_valid <= 1'b1;
        hold_count <= hold_count - CNT_WIDTH'(1);
        for (int i = 0; i < SLOTS - 1; i++) hold_buf[i] <= hold_buf[i+1];
      end

      // The count is one bit wider than the length field so saturation can never alias a legal length.
      if (payload_word) begin
        accumulator <= fold(accumulator, data_in);
        if (payload_count != '1) payload_count <= payload_count + 1'b1;
      end

      if (parity_word) begin
        packet_parity <= data_in;
        low_pkt_valid <= 1'b1;
        parity_done   <= 1'b1;
        check_pending <= 1'b1;
      end

      if (check_pending) begin
        error     <= (accumulator != packet_parity);
        len_error <= (payload_count != {1'b0, header_reg[DATA_WIDTH-1:ADDR_BITS]});
      end

      if (rst_int_reg) begin
        low_pkt_valid <= 1'b0;
        parity_done   <= 1'b0;
        error         <= 1'b0;
        len_error     <= 1'b0;
        check_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_router_register_p.sv
// Self-checking bench for router_register_p: an XOR-mode and a sum-mode instance share the
// stimulus; expected streams and flags come from a packet-level model kept in the bench.
module tb_router_register_p;

  logic       clk = 1'b0;
  logic       reset, pkt_valid, fifo_full, rst_int_reg;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic [7:0] data_in;

  logic [7:0] dout_x, dout_s;
  logic       dv_x, dv_s, pd_x, pd_s, lpv_x, lpv_s, err_x, err_s, lerr_x, lerr_s, ovf_x, ovf_s;
  logic [1:0] hc_x, hc_s;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] payload_q[$];
  logic [7:0] exp_q[$];
  logic       exp_err_x, exp_err_s, exp_len_err;
  int         exp_buffered;
  logic       pd_early, err_early;

  always #5 clk = ~clk;

  router_register_p #(.DATA_WIDTH(8), .ADDR_BITS(2), .HOLD_DEPTH(2), .PARITY_MODE(0)) dut_x (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in), .fifo_full(fifo_full),
    .rst_int_reg(rst_int_reg), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .dout(dout_x), .dout_valid(dv_x), .parity_done(pd_x), .low_pkt_valid(lpv_x),
    .error(err_x), .len_error(lerr_x), .hold_count(hc_x), .hold_ovf(ovf_x));

  router_register_p #(.DATA_WIDTH(8), .ADDR_BITS(2), .HOLD_DEPTH(2), .PARITY_MODE(1)) dut_s (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in), .fifo_full(fifo_full),
    .rst_int_reg(rst_int_reg), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .dout(dout_s), .dout_valid(dv_s), .parity_done(pd_s), .low_pkt_valid(lpv_s),
    .error(err_s), .len_error(lerr_s), .hold_count(hc_s), .hold_ovf(ovf_s));

  // Every word written to the FIFO must be the next one the model expects.
  always @(negedge clk) begin
    if (dv_x) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL dout_stream: got unexpected word %h, expected none", dout_x);
      end else begin
        logic [7:0] w;
        w = exp_q.pop_front();
        if (dout_x !== w) begin
          tests_failed++;
          $display("[TB] FAIL dout_stream: got %h expected %h", dout_x, w);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    pkt_valid = 0; fifo_full = 0; rst_int_reg = 0; detect_add = 0;
    lfd_state = 0; ld_state = 0; laf_state = 0; full_state = 0; data_in = 8'h00;
  endtask

  // Drives one packet from payload_q and derives expected flags from plain packet arithmetic.
  task automatic drive_packet(input logic [7:0] hdr, input logic [7:0] parity, input int stall_from);
    logic [7:0] acc_x, acc_s;
    int n;
    n = payload_q.size();
    acc_x = hdr;
    acc_s = hdr;
    exp_q.push_back(hdr);
    foreach (payload_q[i]) begin
      acc_x = acc_x ^ payload_q[i];
      acc_s = acc_s + payload_q[i];
      exp_q.push_back(payload_q[i]);
    end
    exp_q.push_back(parity);
    exp_err_x    = (acc_x != parity);
    exp_err_s    = (acc_s != parity);
    exp_len_err  = (n != int'(hdr[7:2]));
    exp_buffered = (stall_from < 0) ? 0 : n + 1 - stall_from;

    clear_inputs(); detect_add = 1; pkt_valid = 1; data_in = hdr; step();
    clear_inputs(); lfd_state = 1; pkt_valid = 1; step();
    for (int i = 0; i <= n; i++) begin
      clear_inputs();
      ld_state  = 1;
      pkt_valid = (i != n);
      data_in   = (i == n) ? parity : payload_q[i];
      fifo_full = (stall_from >= 0) && (i >= stall_from);
      step();
    end
    pd_early  = pd_x;
    err_early = err_x;
    clear_inputs(); step();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      clear_inputs(); laf_state = 1; step();
    end
    clear_inputs(); step();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    step(); step();
    tests_run++;
    if ({dout_x, dv_x, pd_x, lpv_x, err_x, lerr_x, hc_x, ovf_x} !== 16'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %h expected 0000",
               {dout_x, dv_x, pd_x, lpv_x, err_x, lerr_x, hc_x, ovf_x});
    end
    reset = 0;
    step();
  endtask

  task automatic test_good_packet();
    payload_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive_packet(8'h12, 8'h56, -1);
    tests_run++;
    if ({pd_x, lpv_x} !== 2'b11) begin
      tests_failed++; $display("[TB] FAIL good_done_lpv: got %b expected 11", {pd_x, lpv_x});
    end
    tests_run++;
    if (err_x !== 1'b0 || lerr_x !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL good_err_len: got %b%b expected 00", err_x, lerr_x);
    end
    tests_run++;
    if (err_s !== exp_err_s) begin
      tests_failed++; $display("[TB] FAIL good_err_sum: got %b expected %b", err_s, exp_err_s);
    end
    drain(0);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++; $display("[TB] FAIL good_stream_len: got %0d missing expected 0", exp_q.size());
    end
    clear_inputs(); rst_int_reg = 1; step(); clear_inputs();
    tests_run++;
    if ({pd_x, lpv_x, err_s} !== 3'b000) begin
      tests_failed++; $display("[TB] FAIL good_rst_int: got %b expected 000", {pd_x, lpv_x, err_s});
    end
  endtask

  task automatic test_bad_parity();
    payload_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive_packet(8'h12, 8'h57, -1);
    tests_run++;
    if ({pd_early, err_early} !== 2'b10) begin
      tests_failed++; $display("[TB] FAIL bad_err_latency: got %b expected 10", {pd_early, err_early});
    end
    tests_run++;
    if (err_x !== exp_err_x) begin
      tests_failed++; $display("[TB] FAIL bad_err: got %b expected %b", err_x, exp_err_x);
    end
    clear_inputs(); rst_int_reg = 1; step(); clear_inputs();
    tests_run++;
    if (err_x !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL bad_rst_int: got %b expected 0", err_x);
    end
  endtask

  task automatic test_sum_mode();
    payload_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive_packet(8'h12, 8'hBC, -1);
    tests_run++;
    if ({err_s, err_x} !== {exp_err_s, exp_err_x}) begin
      tests_failed++;
      $display("[TB] FAIL sum_err: got %b%b expected %b%b", err_s, err_x, exp_err_s, exp_err_x);
    end
    clear_inputs(); rst_int_reg = 1; step(); clear_inputs();
  endtask

  task automatic test_len_mismatch();
    payload_q = '{8'h11, 8'h22, 8'h33};
    drive_packet(8'h12, 8'h12 ^ 8'h11 ^ 8'h22 ^ 8'h33, -1);
    tests_run++;
    if ({lerr_x, lpv_x, err_x} !== {exp_len_err, 1'b1, exp_err_x}) begin
      tests_failed++;
      $display("[TB] FAIL len_mismatch: got %b expected %b", {lerr_x, lpv_x, err_x},
               {exp_len_err, 1'b1, exp_err_x});
    end
    clear_inputs(); rst_int_reg = 1; step(); clear_inputs();
  endtask

  task automatic test_full_stall();
    exp_q.push_back(8'h12); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    clear_inputs(); detect_add = 1; pkt_valid = 1; data_in = 8'h12; step();
    clear_inputs(); lfd_state = 1; pkt_valid = 1; step();
    clear_inputs(); ld_state = 1; pkt_valid = 1; data_in = 8'h11; step();
    data_in = 8'h22; step();
    fifo_full = 1; data_in = 8'h33; step();
    data_in = 8'h44; step();
    tests_run++;
    if (hc_x !== 2'd2) begin
      tests_failed++; $display("[TB] FAIL stall_count: got %0d expected 2", hc_x);
    end
    clear_inputs(); laf_state = 1; fifo_full = 1; step();
    tests_run++;
    if ({dv_x, hc_x} !== 3'b010) begin
      tests_failed++; $display("[TB] FAIL stall_laf_blocked: got %b expected 010", {dv_x, hc_x});
    end
    fifo_full = 0; step();
    tests_run++;
    if ({dv_x, dout_x, hc_x} !== {1'b1, 8'h33, 2'd1}) begin
      tests_failed++; $display("[TB] FAIL stall_pop1: got %b/%h/%0d expected 1/33/1", dv_x, dout_x, hc_x);
    end
    step();
    tests_run++;
    if ({dv_x, dout_x, hc_x} !== {1'b1, 8'h44, 2'd0}) begin
      tests_failed++; $display("[TB] FAIL stall_pop2: got %b/%h/%0d expected 1/44/0", dv_x, dout_x, hc_x);
    end
    clear_inputs(); ld_state = 1; pkt_valid = 1; fifo_full = 1; data_in = 8'h55; step();
    data_in = 8'h66; step();
    data_in = 8'h77; step();
    tests_run++;
    if ({ovf_x, hc_x} !== 3'b110) begin
      tests_failed++; $display("[TB] FAIL stall_overflow: got %b expected 110", {ovf_x, hc_x});
    end
    clear_inputs(); detect_add = 1; pkt_valid = 1; data_in = 8'h12; step();
    clear_inputs(); step();
    tests_run++;
    if ({ovf_x, hc_x, exp_q.size() == 0} !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL stall_flush: got ovf=%b count=%0d missing=%0d expected 0/0/0", ovf_x, hc_x, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    exp_q.push_back(8'h12); exp_q.push_back(8'h11);
    clear_inputs(); detect_add = 1; pkt_valid = 1; data_in = 8'h12; step();
    clear_inputs(); lfd_state = 1; pkt_valid = 1; step();
    clear_inputs(); ld_state = 1; pkt_valid = 1; data_in = 8'h11; step();
    fifo_full = 1; data_in = 8'h22; step();
    clear_inputs(); reset = 1; step();
    reset = 0;
    tests_run++;
    if ({dout_x, dv_x, pd_x, lpv_x, err_x, lerr_x, hc_x, ovf_x} !== 16'h0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_outputs: got %h expected 0000",
               {dout_x, dv_x, pd_x, lpv_x, err_x, lerr_x, hc_x, ovf_x});
    end
    step();
    payload_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive_packet(8'h12, 8'h56, -1);
    drain(0);
    tests_run++;
    if ({pd_x, err_x, lerr_x, exp_q.size() == 0} !== 4'b1001) begin
      tests_failed++;
      $display("[TB] FAIL midreset_clean: got %b expected 1001", {pd_x, err_x, lerr_x, exp_q.size() == 0});
    end
    clear_inputs(); rst_int_reg = 1; step(); clear_inputs();
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      int n, len_f, buffered, stall_from, sel;
      logic [7:0] hdr, good_x, good_s, parity;
      n = $urandom_range(0, 5);
      len_f = n;
      if ($urandom_range(0, 3) == 0) len_f = (n > 0 && $urandom_range(0, 1) == 1) ? n - 1 : n + 1;
      hdr = {6'(len_f), 2'($urandom_range(0, 2))};
      payload_q.delete();
      good_x = hdr;
      good_s = hdr;
      for (int i = 0; i < n; i++) begin
        payload_q.push_back(8'($urandom));
        good_x = good_x ^ payload_q[i];
        good_s = good_s + payload_q[i];
      end
      sel = $urandom_range(0, 3);
      parity = (sel < 2) ? good_x : (sel == 2) ? good_s : 8'($urandom);
      stall_from = -1;
      if ($urandom_range(0, 2) != 0) begin
        buffered = $urandom_range(1, 2);
        stall_from = (n + 1 - buffered < 0) ? 0 : n + 1 - buffered;
      end
      drive_packet(hdr, parity, stall_from);
      tests_run++;
      if ({pd_x, lpv_x, err_x, err_s, lerr_x} !== {2'b11, exp_err_x, exp_err_s, exp_len_err}) begin
        tests_failed++;
        $display("[TB] FAIL random_flags[%0d]: got %b expected %b", k,
                 {pd_x, lpv_x, err_x, err_s, lerr_x}, {2'b11, exp_err_x, exp_err_s, exp_len_err});
      end
      drain(exp_buffered);
      tests_run++;
      if (exp_q.size() != 0 || hc_x !== 2'd0) begin
        tests_failed++;
        $display("[TB] FAIL random_drain[%0d]: got %0d missing, count %0d expected 0, 0", k, exp_q.size(), hc_x);
        exp_q.delete();
      end
      clear_inputs(); rst_int_reg = 1; step(); clear_inputs();
      tests_run++;
      if ({pd_x, lpv_x, err_x, lerr_x} !== 4'b0000) begin
        tests_failed++;
        $display("[TB] FAIL random_rst_int[%0d]: got %b expected 0000", k, {pd_x, lpv_x, err_x, lerr_x});
      end
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_good_packet();
    test_bad_parity();
    test_sum_mode();
    test_len_mismatch();
    test_full_stall();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
